// File: rtl/i2c_master.sv
// I2C master bit engine: issues START, STOP, byte WRITE and byte READ on an
// open-drain bus, one command at a time, with SCL clock stretching.
// Ports:
//   clk, res         - system clock, synchronous active-high reset
//   cmd_wr, cmd      - command strobe and code (1 START 2 STOP 3 WRITE
//                      4 READ_ACK 5 READ_NACK)
//   wr_data          - byte to send on WRITE
//   scl_in, sda_in   - bus pin levels
//   scl_oe, sda_oe   - 1 pulls the line low, 0 releases it
//   rd_data, nack    - last byte read, ACK bit seen on last WRITE
//   busy, done       - command in progress, one-cycle completion pulse
module i2c_master #(
   parameter int CLK_DIV = 125
) (
   input  logic       clk,
   input  logic       res,
   input  logic       cmd_wr,
   input  logic [2:0] cmd,
   input  logic [7:0] wr_data,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       scl_oe,
   output logic       sda_oe,
   output logic [7:0] rd_data,
   output logic       nack,
   output logic       busy,
   output logic       done
);

   localparam int CW = $clog2(CLK_DIV + 1);

   typedef enum logic [1:0] {IDLE, START, STOP, DATA} state_t;

   state_t     state;
   logic [CW-1:0] cnt;
   logic [1:0] phase;
   logic [3:0] bit_cnt;
   logic [7:0] data_q;
   logic       rd_q;
   logic       ack_q;
   logic [7:0] shift_q;

   logic cmd_ok;
   logic stall;
   logic ph_end;
   logic last_bit;

   assign cmd_ok   = (cmd >= 3'd1) && (cmd <= 3'd5);
   // The slave may hold SCL low while we have released it in P1.
   assign stall    = (phase == 2'd1) && !scl_oe && !scl_in;
   assign ph_end   = (cnt == CW'(CLK_DIV - 1)) && !stall;
   assign last_bit = (state != DATA) || (bit_cnt == 4'd8);

   // Bus levels {scl_oe, sda_oe} for a given state, phase and bit.
   function automatic logic [1:0] bus_oe(
      input state_t     st,
      input logic [1:0] ph,
      input logic [3:0] b,
      input logic [7:0] d,
      input logic       rd,
      input logic       ack,
      input logic       scl_cur
   );
      logic s;
      logic [1:0] r;
      r = 2'b00;
      if (b == 4'd8) s = rd & ack;
      else           s = rd ? 1'b0 : ~d[3'(4'd7 - b)];
      unique case (st)
         START: begin
            unique case (ph)
               2'd0:    r = {scl_cur, 1'b0};
               2'd1:    r = 2'b00;
               2'd2:    r = 2'b01;
               default: r = 2'b11;
            endcase
         end
         STOP: begin
            unique case (ph)
               2'd0:    r = 2'b11;
               2'd1:    r = 2'b01;
               default: r = 2'b00;
            endcase
         end
         DATA: r = {(ph == 2'd0) || (ph == 2'd3), s};
         default: r = 2'b00;
      endcase
      return r;
   endfunction

   always_ff @(posedge clk) begin
      if (res) begin
         state   <= IDLE;
         cnt     <= '0;
         phase   <= 2'd0;
         bit_cnt <= 4'd0;
         data_q  <= 8'h00;
         rd_q    <= 1'b0;
         ack_q   <= 1'b0;
         shift_q <= 8'h00;
         scl_oe  <= 1'b0;
         sda_oe  <= 1'b0;
         rd_data <= 8'h00;
         nack    <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            cnt     <= '0;
            phase   <= 2'd0;
            bit_cnt <= 4'd0;
            if (cmd_wr && cmd_ok) begin
               state  <= (cmd == 3'd1) ? START :
                         (cmd == 3'd2) ? STOP : DATA;
               busy   <= 1'b1;
               data_q <= wr_data;
               rd_q   <= cmd[2];
               ack_q  <= (cmd == 3'd4);
               {scl_oe, sda_oe} <= bus_oe(
                  (cmd == 3'd1) ? START :
                  (cmd == 3'd2) ? STOP : DATA,
                  2'd0, 4'd0, wr_data, cmd[2],
                  cmd == 3'd4, scl_oe);
            end
         end else if (ph_end) begin
            cnt <= '0;
            if (state == DATA && phase == 2'd1) begin
               if (rd_q && bit_cnt != 4'd8)
                  shift_q <= {shift_q[6:0], sda_in};
               if (!rd_q && bit_cnt == 4'd8)
                  nack <= sda_in;
            end
            if (phase == 2'd3) begin
               if (last_bit) begin
                  state <= IDLE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  if (state == DATA && rd_q)
                     rd_data <= shift_q;
               end else begin
                  phase   <= 2'd0;
                  bit_cnt <= bit_cnt + 4'd1;
                  {scl_oe, sda_oe} <= bus_oe(state, 2'd0,
                     bit_cnt + 4'd1, data_q, rd_q, ack_q, scl_oe);
               end
            end else begin
               phase <= phase + 2'd1;
               {scl_oe, sda_oe} <= bus_oe(state, phase + 2'd1,
                  bit_cnt, data_q, rd_q, ack_q, scl_oe);
            end
         end else if (!stall) begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule
